// File: rtl/renode_ahb_apb_bridge.sv
// AHB-Lite subordinate to APB4 bridge. It accepts single 32-bit word transfers and turns
// each one into one APB SETUP+ACCESS pair. APB wait states and errors go back on hreadyout/hresp.
module renode_ahb_apb_bridge #(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    hsel,
  input  logic [AddressWidth-1:0] haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic                    hready,
  input  logic [DataWidth-1:0]    hwdata,
  input  logic [DataWidth/8-1:0]  hwstrb,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DataWidth-1:0]    hrdata,
  output logic [AddressWidth-1:0] paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DataWidth-1:0]    pwdata,
  output logic [DataWidth/8-1:0]  pstrb,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  if (DataWidth != 32) begin : g_width_check
    $fatal(1, "renode_ahb_apb_bridge: only DataWidth=32 is supported");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    ERR1   = 3'd3,
    ERR2   = 3'd4
  } state_e;

  state_e                  state_r, next_state_s;
  logic                    accept_s, legal_s, capture_s, read_done_s;
  logic                    hreadyout_s, hresp_s, psel_s, penable_s;
  logic                    hreadyout_r, hresp_r, psel_r, penable_r, pwrite_r;
  logic [AddressWidth-1:0] paddr_r;
  logic [DataWidth-1:0]    hrdata_r;

  assign accept_s    = hsel & hready & htrans[1];
  assign legal_s     = (hsize == 3'b010) && (hburst == 3'b000);
  assign read_done_s = (state_r == ACCESS) && pready && !pslverr && !pwrite_r;

  // Next-state decode; new transfers are only taken in IDLE and ERR2.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    case (state_r)
      IDLE, ERR2: begin
        if (accept_s) begin
          capture_s    = 1'b1;
          next_state_s = legal_s ? SETUP : ERR1;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETUP:  next_state_s = ACCESS;
      ACCESS: begin
        if (pready) begin
          next_state_s = pslverr ? ERR1 : IDLE;
        end else begin
          next_state_s = ACCESS;
        end
      end
      ERR1:    next_state_s = ERR2;
      default: next_state_s = IDLE;
    endcase
  end

  // Per-state output values, computed from the next state so the outputs can be registered.
  always_comb begin
    hreadyout_s = 1'b1;
    hresp_s     = 1'b0;
    psel_s      = 1'b0;
    penable_s   = 1'b0;
    case (next_state_s)
      IDLE:   hreadyout_s = 1'b1;
      SETUP: begin
        hreadyout_s = 1'b0;
        psel_s      = 1'b1;
      end
      ACCESS: begin
        hreadyout_s = 1'b0;
        psel_s      = 1'b1;
        penable_s   = 1'b1;
      end
      ERR1: begin
        hreadyout_s = 1'b0;
        hresp_s     = 1'b1;
      end
      ERR2: begin
        hreadyout_s = 1'b1;
        hresp_s     = 1'b1;
      end
      default: hreadyout_s = 1'b1;
    endcase
  end

  // State and registered handshake outputs.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r     <= IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      hreadyout_r <= hreadyout_s;
      hresp_r     <= hresp_s;
      psel_r      <= psel_s;
      penable_r   <= penable_s;
    end
  end

  // Address/direction captured at acceptance; they hold until the next accepted transfer.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      paddr_r  <= {AddressWidth{1'b0}};
      pwrite_r <= 1'b0;
    end else if (capture_s) begin
      paddr_r  <= haddr;
      pwrite_r <= hwrite;
    end else begin
      paddr_r  <= paddr_r;
      pwrite_r <= pwrite_r;
    end
  end

  // Read data holds across writes and errors; only a clean read completion updates it.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      hrdata_r <= {DataWidth{1'b0}};
    end else if (read_done_s) begin
      hrdata_r <= prdata;
    end else begin
      hrdata_r <= hrdata_r;
    end
  end

  assign hreadyout = hreadyout_r;
  assign hresp     = hresp_r;
  assign hrdata    = hrdata_r;
  assign psel      = psel_r;
  assign penable   = penable_r;
  assign paddr     = paddr_r;
  assign pwrite    = pwrite_r;
  // The manager holds hwdata through the stalled data phase, so a pass-through is stable on APB.
  assign pwdata    = psel_r ? hwdata : {DataWidth{1'b0}};
  assign pstrb     = pwrite_r ? hwstrb : {(DataWidth/8){1'b0}};

endmodule
